mul_rs: RTL and testbench
=========================

# mul_rs

Reservation station for the multiply unit in the out-of-order core. Holds up to DEPTH dispatched multiply instructions and wakes their source operands by snooping the common data bus (CDB). Issues one operand-complete instruction at a time, from a registered output stage, to the `mul` unit's `mul_request_i` / `inst_i` / `pc_i` / `rs1_value_i` / `rs2_value_i` inputs. Sits between dispatch/rename and `mul`.

## Interface
- DEPTH, 4, number of entries (≥2)
- TAG_W, 5, physical/ROB tag width
- clk_i  in  1  clock; all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries and the output stage (mispredict)
- dispatch_valid_i  in  1  new instruction offered
- dispatch_ready_o  out  1  station can accept (not full)
- dispatch_pc_i  in  32  instruction PC
- dispatch_inst_i  in  32  raw instruction word
- dispatch_dest_tag_i  in  TAG_W  destination tag
- rs1_ready_i / rs2_ready_i  in  1  operand value already valid
- rs1_tag_i / rs2_tag_i  in  TAG_W  producer tag when not ready
- rs1_value_i / rs2_value_i  in  32  operand value when ready
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  32  broadcast value
- mul_ready_i  in  1  mul accepts a request this cycle (tie high for a fully pipelined mul)
- mul_request_o  out  1  issue valid
- pc_o, inst_o  out  32  issued PC / instruction
- rs1_value_o, rs2_value_o  out  32  issued operands
- dest_tag_o  out  TAG_W  issued destination tag

## Operation
- Each entry holds: valid, pc, inst, dest_tag, and per source a ready bit, tag, and value.
- Dispatch fires when dispatch_valid_i && dispatch_ready_o. It writes the lowest-index free entry.
  - A source with rsN_ready_i=0 whose tag matches a same-cycle CDB broadcast is written ready, with cdb_value_i.
- Wakeup: every valid entry with a non-ready source whose tag equals cdb_tag_i while cdb_valid_i is high captures cdb_value_i and sets ready at the edge.
- Eligible: valid and both sources ready, using registered ready bits. A source woken this cycle is eligible next cycle.
- Output stage is one register set. It loads when it is empty or mul_ready_i=1.
  - When it loads and an eligible entry exists, the selected entry is copied in and freed at the same edge, and mul_request_o=1.
  - When it loads and no entry is eligible, mul_request_o goes to 0.
  - When it holds a request and mul_ready_i=0, all output values hold.
- dispatch_ready_o = not all entries valid, derived from registered state only. An entry freed this cycle is reusable next cycle.
- flush_i clears all valids and mul_request_o at the edge. It overrides same-cycle dispatch, wakeup and issue.
- reset_i: all entries invalid; mul_request_o=0; pc_o, inst_o, rs1_value_o, rs2_value_o, dest_tag_o = 0; dispatch_ready_o=1.
- Wakeup, dispatch and issue in the same cycle on different entries all take effect.

## Timing
- Dispatch with both sources ready, station empty, mul_ready_i=1: mul_request_o high 2 edges after the dispatch edge (edge 1 writes the entry, edge 2 loads the output stage).
- CDB wakeup edge to mul_request_o high: 2 edges, given a free output stage.
- Sustained throughput: 1 issue per cycle when mul_ready_i=1 and entries are eligible.
- No combinational path from any input to dispatch_ready_o or any issue output.

## Configuration
- MUL_RS_AGE_ORDER_EN defined: select the oldest eligible entry. Age is tracked with a DEPTH×DEPTH age matrix.
  - On allocate of entry i: row i is cleared; column i is set for every currently valid entry.
  - Freed entries need no matrix update.
- Not defined: select the lowest-index eligible entry. No age matrix is built.

## Structure
- Shared package `ooo_pkg` holds: TAG_W default, typedef `mul_rs_entry_t` (entry fields), and typedef `mul_issue_t` (issue bundle).
- Sub-module `mul_rs_picker`: takes the eligible vector (plus the age matrix when MUL_RS_AGE_ORDER_EN) and produces a one-hot grant and a found flag.

## Test plan
- Reset, then DEPTH dispatches, rs1=3 and rs2=5 ready, mul_ready_i=1 -> four issues on consecutive cycles with rs1_value_o=3 and rs2_value_o=5; dispatch_ready_o stays 1.
- Dispatch with rs1 waiting on tag 7 and rs2=2 ready; two cycles later CDB tag 7, value 0x10 -> mul_request_o high 2 edges after the broadcast, rs1_value_o=0x10.
- Dispatch with rs1_tag=9 in the same cycle as CDB tag 9, value 0xAB -> entry captures 0xAB and issues 2 edges later; no hang.
- Fill DEPTH entries all waiting on tag 4 -> dispatch_ready_o=0. With mul_ready_i=0, broadcast tag 4 -> one request holds stable until mul_ready_i=1, then the rest drain. With MUL_RS_AGE_ORDER_EN, issue order equals dispatch order.
- Flush in the same cycle as a dispatch while one request is held -> next cycle mul_request_o=0, dispatch_ready_o=1, the new instruction is never issued.
- reset_i asserted mid-drain -> all outputs at reset values after the edge; no stale issue afterwards.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: reservation-station entry and multiply issue bundle.
package ooo_pkg;

   localparam int OOO_TAG_W = 5;

   typedef struct packed {
      logic                 valid;
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic [OOO_TAG_W-1:0] dest_tag;
      logic                 rs1_ready;
      logic [OOO_TAG_W-1:0] rs1_tag;
      logic [31:0]          rs1_value;
      logic                 rs2_ready;
      logic [OOO_TAG_W-1:0] rs2_tag;
      logic [31:0]          rs2_value;
   } mul_rs_entry_t;

   typedef struct packed {
      logic                 valid;
      logic [31:0]          pc;
      logic [31:0]          inst;
      logic [31:0]          rs1_value;
      logic [31:0]          rs2_value;
      logic [OOO_TAG_W-1:0] dest_tag;
   } mul_issue_t;

endpackage

// File: rtl/mul_rs_if.sv
// Dispatch, CDB and issue signals of the multiply reservation station.
interface mul_rs_if
   import ooo_pkg::*;
#(
   parameter int TAG_W = OOO_TAG_W
);
   logic             dispatch_valid_i;
   logic             dispatch_ready_o;
   logic [31:0]      dispatch_pc_i;
   logic [31:0]      dispatch_inst_i;
   logic [TAG_W-1:0] dispatch_dest_tag_i;
   logic             rs1_ready_i;
   logic             rs2_ready_i;
   logic [TAG_W-1:0] rs1_tag_i;
   logic [TAG_W-1:0] rs2_tag_i;
   logic [31:0]      rs1_value_i;
   logic [31:0]      rs2_value_i;
   logic             cdb_valid_i;
   logic [TAG_W-1:0] cdb_tag_i;
   logic [31:0]      cdb_value_i;
   logic             mul_ready_i;
   logic             mul_request_o;
   logic [31:0]      pc_o;
   logic [31:0]      inst_o;
   logic [31:0]      rs1_value_o;
   logic [31:0]      rs2_value_o;
   logic [TAG_W-1:0] dest_tag_o;

   modport slave (
      input  dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_dest_tag_i,
      input  rs1_ready_i, rs2_ready_i, rs1_tag_i, rs2_tag_i, rs1_value_i, rs2_value_i,
      input  cdb_valid_i, cdb_tag_i, cdb_value_i, mul_ready_i,
      output dispatch_ready_o, mul_request_o, pc_o, inst_o,
      output rs1_value_o, rs2_value_o, dest_tag_o
   );

   modport master (
      output dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_dest_tag_i,
      output rs1_ready_i, rs2_ready_i, rs1_tag_i, rs2_tag_i, rs1_value_i, rs2_value_i,
      output cdb_valid_i, cdb_tag_i, cdb_value_i, mul_ready_i,
      input  dispatch_ready_o, mul_request_o, pc_o, inst_o,
      input  rs1_value_o, rs2_value_o, dest_tag_o
   );
endinterface

// File: rtl/mul_rs_picker.sv
// Issue selector: one-hot grant over eligible entries. With MUL_RS_AGE_ORDER_EN the
// oldest eligible entry wins (age matrix input), otherwise the lowest index wins.
module mul_rs_picker #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]            eligible_i,
`ifdef MUL_RS_AGE_ORDER_EN
   input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
`endif
   output logic [DEPTH-1:0]            grant_o,
   output logic                        found_o
);
   assign found_o = |eligible_i;

`ifdef MUL_RS_AGE_ORDER_EN
   // age_i[j][i] set means entry j was allocated before entry i
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
      logic [DEPTH-1:0] older_vec;
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_row
         if (gj == gi) begin : g_self
            assign older_vec[gj] = 1'b0;
         end else begin : g_other
            assign older_vec[gj] = age_i[gj][gi] & eligible_i[gj];
         end
      end
      assign grant_o[gi] = eligible_i[gi] & ~(|older_vec);
   end
`else
   assign grant_o = eligible_i & (~eligible_i + DEPTH'(1));
`endif

endmodule

// File: rtl/mul_rs.sv
// Multiply reservation station: CDB wakeup, single registered issue stage.
// Optional oldest-first selection when MUL_RS_AGE_ORDER_EN is defined.
module mul_rs
   import ooo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = OOO_TAG_W
) (
   input logic     clk_i,
   input logic     reset_i,
   input logic     flush_i,
   mul_rs_if.slave bus
);
   mul_rs_entry_t    entries_q [DEPTH];
   mul_rs_entry_t    entries_d [DEPTH];
   mul_rs_entry_t    new_entry;
   mul_issue_t       out_q, out_d;
   logic [DEPTH-1:0] valid_vec, eligible_vec, grant_vec, alloc_vec;
   logic             found, dispatch_fire, load, issue_fire;
   logic [TAG_W-1:0] cdb_tag;

   assign cdb_tag = bus.cdb_tag_i;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
      assign valid_vec[gi]    = entries_q[gi].valid;
      assign eligible_vec[gi] = entries_q[gi].valid & entries_q[gi].rs1_ready &
                                entries_q[gi].rs2_ready;
   end

   // lowest free slot
   assign alloc_vec     = ~valid_vec & (valid_vec + DEPTH'(1));
   assign dispatch_fire = bus.dispatch_valid_i & ~(&valid_vec);
   assign load          = ~out_q.valid | bus.mul_ready_i;
   assign issue_fire    = load & found;

`ifdef MUL_RS_AGE_ORDER_EN
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

   always_comb begin
      age_d = age_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (dispatch_fire && alloc_vec[i]) begin
            age_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
               if (valid_vec[j]) age_d[j][i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) age_q <= '0;
      else         age_q <= age_d;
   end

   mul_rs_picker #(.DEPTH(DEPTH)) u_picker (
      .eligible_i (eligible_vec),
      .age_i      (age_q),
      .grant_o    (grant_vec),
      .found_o    (found)
   );
`else
   mul_rs_picker #(.DEPTH(DEPTH)) u_picker (
      .eligible_i (eligible_vec),
      .grant_o    (grant_vec),
      .found_o    (found)
   );
`endif

   // a source still waiting at dispatch may be satisfied by this cycle's broadcast
   always_comb begin
      new_entry           = '0;
      new_entry.valid     = 1'b1;
      new_entry.pc        = bus.dispatch_pc_i;
      new_entry.inst      = bus.dispatch_inst_i;
      new_entry.dest_tag  = bus.dispatch_dest_tag_i;
      new_entry.rs1_tag   = bus.rs1_tag_i;
      new_entry.rs2_tag   = bus.rs2_tag_i;
      new_entry.rs1_ready = bus.rs1_ready_i | (bus.cdb_valid_i & (bus.rs1_tag_i == cdb_tag));
      new_entry.rs2_ready = bus.rs2_ready_i | (bus.cdb_valid_i & (bus.rs2_tag_i == cdb_tag));
      new_entry.rs1_value = bus.rs1_ready_i ? bus.rs1_value_i : bus.cdb_value_i;
      new_entry.rs2_value = bus.rs2_ready_i ? bus.rs2_value_i : bus.cdb_value_i;
   end

   always_comb begin
      entries_d = entries_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.cdb_valid_i && entries_q[i].valid) begin
            if (!entries_q[i].rs1_ready && entries_q[i].rs1_tag == cdb_tag) begin
               entries_d[i].rs1_ready = 1'b1;
               entries_d[i].rs1_value = bus.cdb_value_i;
            end
            if (!entries_q[i].rs2_ready && entries_q[i].rs2_tag == cdb_tag) begin
               entries_d[i].rs2_ready = 1'b1;
               entries_d[i].rs2_value = bus.cdb_value_i;
            end
         end
         if (issue_fire && grant_vec[i]) entries_d[i].valid = 1'b0;
         if (dispatch_fire && alloc_vec[i]) entries_d[i] = new_entry;
         if (flush_i) entries_d[i].valid = 1'b0;
      end
   end

   // an empty load drops the request but keeps the last payload
   always_comb begin
      out_d = out_q;
      if (flush_i) begin
         out_d.valid = 1'b0;
      end else if (load) begin
         out_d.valid = found;
         for (int i = 0; i < DEPTH; i++) begin
            if (grant_vec[i]) begin
               out_d.pc        = entries_q[i].pc;
               out_d.inst      = entries_q[i].inst;
               out_d.rs1_value = entries_q[i].rs1_value;
               out_d.rs2_value = entries_q[i].rs2_value;
               out_d.dest_tag  = entries_q[i].dest_tag;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         out_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
         out_q <= out_d;
      end
   end

   assign bus.dispatch_ready_o = ~(&valid_vec);
   assign bus.mul_request_o    = out_q.valid;
   assign bus.pc_o             = out_q.pc;
   assign bus.inst_o           = out_q.inst;
   assign bus.rs1_value_o      = out_q.rs1_value;
   assign bus.rs2_value_o      = out_q.rs2_value;
   assign bus.dest_tag_o       = out_q.dest_tag;

endmodule

// File: tb/tb_mul_rs.sv
// Randomized scoreboard bench for mul_rs against an instruction-level reference model.
module tb_mul_rs;
   import ooo_pkg::*;

   localparam int DEPTH = 4;
   localparam int TW    = OOO_TAG_W;

   logic clk_i = 1'b0;
   logic reset_i, flush_i;

   mul_rs_if #(.TAG_W(TW)) bus ();

   mul_rs #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          v;
      bit [31:0]   pc, inst;
      bit [TW-1:0] dest;
      bit          r1, r2;
      bit [TW-1:0] t1, t2;
      bit [31:0]   v1, v2;
      int          seq;
   } slot_t;

   typedef struct {
      bit [31:0]   pc, inst, a, b;
      bit [TW-1:0] dest;
   } iss_t;

   slot_t m_slot [DEPTH];
   bit    m_ov;
   iss_t  m_out;
   int    seq_ctr;
   iss_t  exp_q [$];
   iss_t  mon_e;
   int    vectors, miscompares;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic bit model_full();
      for (int i = 0; i < DEPTH; i++) if (!m_slot[i].v) return 1'b0;
      return 1'b1;
   endfunction

   // Advance the instruction-level model across the coming edge using current inputs.
   task automatic model_step();
      bit full;
      int free_idx, pick;
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) m_slot[i].v = 0;
         m_ov = 0;
         m_out = '{default: 0};
         return;
      end
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) m_slot[i].v = 0;
         m_ov = 0;
         return;
      end
      if (m_ov && bus.mul_ready_i) exp_q.push_back(m_out);
      full = model_full();
      free_idx = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_slot[i].v && free_idx < 0) free_idx = i;
      pick = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_slot[i].v && m_slot[i].r1 && m_slot[i].r2) begin
`ifdef MUL_RS_AGE_ORDER_EN
            if (pick < 0 || m_slot[i].seq < m_slot[pick].seq) pick = i;
`else
            if (pick < 0) pick = i;
`endif
         end
      end
      if (!m_ov || bus.mul_ready_i) begin
         if (pick >= 0) begin
            m_ov = 1;
            m_out.pc   = m_slot[pick].pc;
            m_out.inst = m_slot[pick].inst;
            m_out.a    = m_slot[pick].v1;
            m_out.b    = m_slot[pick].v2;
            m_out.dest = m_slot[pick].dest;
            m_slot[pick].v = 0;
         end else begin
            m_ov = 0;
         end
      end
      if (bus.cdb_valid_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_slot[i].v && !m_slot[i].r1 && m_slot[i].t1 == bus.cdb_tag_i) begin
               m_slot[i].r1 = 1; m_slot[i].v1 = bus.cdb_value_i;
            end
            if (m_slot[i].v && !m_slot[i].r2 && m_slot[i].t2 == bus.cdb_tag_i) begin
               m_slot[i].r2 = 1; m_slot[i].v2 = bus.cdb_value_i;
            end
         end
      end
      if (bus.dispatch_valid_i && !full) begin
         m_slot[free_idx].v    = 1;
         m_slot[free_idx].pc   = bus.dispatch_pc_i;
         m_slot[free_idx].inst = bus.dispatch_inst_i;
         m_slot[free_idx].dest = bus.dispatch_dest_tag_i;
         m_slot[free_idx].t1   = bus.rs1_tag_i;
         m_slot[free_idx].t2   = bus.rs2_tag_i;
         m_slot[free_idx].r1   = bus.rs1_ready_i || (bus.cdb_valid_i && bus.rs1_tag_i == bus.cdb_tag_i);
         m_slot[free_idx].r2   = bus.rs2_ready_i || (bus.cdb_valid_i && bus.rs2_tag_i == bus.cdb_tag_i);
         m_slot[free_idx].v1   = bus.rs1_ready_i ? bus.rs1_value_i : bus.cdb_value_i;
         m_slot[free_idx].v2   = bus.rs2_ready_i ? bus.rs2_value_i : bus.cdb_value_i;
         m_slot[free_idx].seq  = seq_ctr++;
      end
   endtask

   task automatic check_outputs();
      chk("mul_request", 32'(bus.mul_request_o), 32'(m_ov));
      chk("dispatch_ready", 32'(bus.dispatch_ready_o), 32'(!model_full()));
      chk("pc_o", bus.pc_o, m_out.pc);
      chk("inst_o", bus.inst_o, m_out.inst);
      chk("rs1_value_o", bus.rs1_value_o, m_out.a);
      chk("rs2_value_o", bus.rs2_value_o, m_out.b);
      chk("dest_tag_o", 32'(bus.dest_tag_o), 32'(m_out.dest));
   endtask

   task automatic idle();
      reset_i = 0;
      flush_i = 0;
      bus.dispatch_valid_i = 0;
      bus.cdb_valid_i = 0;
   endtask

   task automatic set_dispatch(input bit [31:0] pc, input bit [TW-1:0] dest,
                               input bit r1, input bit [TW-1:0] t1, input bit [31:0] v1,
                               input bit r2, input bit [TW-1:0] t2, input bit [31:0] v2);
      bus.dispatch_valid_i    = 1;
      bus.dispatch_pc_i       = pc;
      bus.dispatch_inst_i     = 32'h0200_0033 ^ pc;
      bus.dispatch_dest_tag_i = dest;
      bus.rs1_ready_i = r1; bus.rs1_tag_i = t1; bus.rs1_value_i = v1;
      bus.rs2_ready_i = r2; bus.rs2_tag_i = t2; bus.rs2_value_i = v2;
   endtask

   task automatic set_cdb(input bit [TW-1:0] tag, input bit [31:0] value);
      bus.cdb_valid_i = 1;
      bus.cdb_tag_i   = tag;
      bus.cdb_value_i = value;
   endtask

   task automatic step();
      model_step();
      @(posedge clk_i);
      #1;
      check_outputs();
      idle();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Monitor: every accepted request must match the oldest predicted issue.
   always @(negedge clk_i) begin
      if (!reset_i && !flush_i && bus.mul_request_o && bus.mul_ready_i) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_unexpected: got pc 0x%08h expected no issue", bus.pc_o);
         end else begin
            mon_e = exp_q.pop_front();
            $display("issue pc=0x%08h dest=%0d a=0x%08h b=0x%08h",
                     bus.pc_o, bus.dest_tag_o, bus.rs1_value_o, bus.rs2_value_o);
            chk("issue_pc", bus.pc_o, mon_e.pc);
            chk("issue_inst", bus.inst_o, mon_e.inst);
            chk("issue_rs1", bus.rs1_value_o, mon_e.a);
            chk("issue_rs2", bus.rs2_value_o, mon_e.b);
            chk("issue_dest", 32'(bus.dest_tag_o), 32'(mon_e.dest));
         end
      end
   end

   initial begin
      vectors = 0; miscompares = 0; seq_ctr = 0;
      m_ov = 0; m_out = '{default: 0};
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '{default: 0};
      bus.dispatch_pc_i = 0; bus.dispatch_inst_i = 0; bus.dispatch_dest_tag_i = 0;
      bus.rs1_ready_i = 0; bus.rs2_ready_i = 0; bus.rs1_tag_i = 0; bus.rs2_tag_i = 0;
      bus.rs1_value_i = 0; bus.rs2_value_i = 0; bus.cdb_tag_i = 0; bus.cdb_value_i = 0;
      bus.mul_ready_i = 1;
      idle();

      reset_i = 1; step();
      reset_i = 1; step();

      // back-to-back ready instructions
      for (int k = 0; k < DEPTH; k++) begin
         set_dispatch(32'h100 + 32'(4 * k), TW'(k), 1, 0, 3, 1, 0, 5);
         step();
      end
      steps(4);

      // wakeup two cycles after dispatch
      set_dispatch(32'h200, 5'd10, 0, 5'd7, 0, 1, 0, 2); step();
      steps(1);
      set_cdb(5'd7, 32'h10); step();
      steps(3);

      // wakeup in the dispatch cycle
      set_dispatch(32'h300, 5'd11, 0, 5'd9, 0, 1, 0, 1);
      set_cdb(5'd9, 32'hAB); step();
      steps(3);

      // fill with waiters on tag 4, then stall the issue port
      for (int k = 0; k < DEPTH; k++) begin
         set_dispatch(32'h400 + 32'(4 * k), TW'(12 + k), 0, 5'd4, 0, 1, 0, 32'(k));
         step();
      end
      set_dispatch(32'h4F0, 5'd20, 1, 0, 1, 1, 0, 1); step();
      bus.mul_ready_i = 0;
      set_cdb(5'd4, 32'h44); step();
      steps(4);
      bus.mul_ready_i = 1;
      steps(6);

      // flush with a held request and a same-cycle dispatch
      bus.mul_ready_i = 0;
      set_dispatch(32'h500, 5'd21, 1, 0, 7, 1, 0, 8); step();
      steps(2);
      flush_i = 1;
      set_dispatch(32'h504, 5'd22, 1, 0, 9, 1, 0, 9); step();
      bus.mul_ready_i = 1;
      steps(4);

      // reset during a drain
      for (int k = 0; k < DEPTH; k++) begin
         set_dispatch(32'h600 + 32'(4 * k), TW'(k), 1, 0, 32'(k), 1, 0, 6);
         step();
      end
      reset_i = 1; step();
      steps(4);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 9) < 6)
            set_dispatch($urandom, TW'($urandom), 1'($urandom), TW'($urandom_range(0, 7)), $urandom,
                         1'($urandom), TW'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 1) == 1) set_cdb(TW'($urandom_range(0, 7)), $urandom);
         bus.mul_ready_i = ($urandom_range(0, 9) < 7);
         flush_i = ($urandom_range(0, 49) == 0);
         reset_i = ($urandom_range(0, 199) == 0);
         step();
      end

      // wake every possible tag, then drain
      bus.mul_ready_i = 1;
      for (int t = 0; t < (1 << TW); t++) begin
         set_cdb(TW'(t), 32'(t) * 32'h0101);
         step();
      end
      steps(8);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
